instr_fetch_stage: RTL and testbench
====================================

// Module: instr_fetch_stage
// PURPOSE
//  Fetch stage of the single-cycle-derived CPU: owns the PC, handshakes with instruction memory, and holds the fetched word.
//  Presents INSTR plus the upper-immediate field IMM20 (INSTR[31:12]) to decode; IMM20 feeds the 20->32 zero-fill extender directly.
//  Supports downstream stall (HOLD), control-flow redirect, and a memory-wait watchdog.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  PC_STEP    4              PC increment per accepted fetch (bytes)
//  TIMEOUT    8              max cycles waiting for IMEM_ACK before error (1..255)
// PORTS
//  CLK          in   1   system clock, all state on rising edge
//  RST          in   1   synchronous reset, active-high
//  IMEM_REQ     out  1   fetch request; high exactly while state==FETCH
//  IMEM_ADDR    out  32  address of request (= PC)
//  IMEM_ACK     in   1   memory returns IMEM_RDATA this cycle
//  IMEM_RDATA   in   32  instruction word, valid when IMEM_ACK
//  HOLD         in   1   decode stall; INSTR must be held
//  REDIRECT     in   1   branch/jump taken; discard current fetch
//  REDIRECT_PC  in   32  new PC when REDIRECT
//  INSTR        out  32  fetched instruction (registered)
//  INSTR_PC     out  32  PC of INSTR
//  IMM20        out  20  INSTR[31:12], registered with INSTR
//  INSTR_VALID  out  1   INSTR/INSTR_PC/IMM20 valid
//  FETCH_ERR    out  1   sticky watchdog error
// BEHAVIOUR
//  Reset: one clock with RST=1 synchronous; state=IDLE, PC=RESET_PC, INSTR=0, INSTR_PC=0, IMM20=0, INSTR_VALID=0, FETCH_ERR=0, wait counter=0.
//  States: IDLE, FETCH, OUT, ERR. IMEM_REQ=(state==FETCH), IMEM_ADDR=PC (combinational).
//  IDLE -> FETCH unconditionally next cycle (first IMEM_REQ on 2nd edge after RST release).
//  FETCH: if IMEM_ACK: INSTR<=IMEM_RDATA, IMM20<=IMEM_RDATA[31:12], INSTR_PC<=PC, PC<=PC+PC_STEP (mod 2^32 wrap), INSTR_VALID<=1, wait cnt<=0, -> OUT.
//    else wait cnt++; when cnt reaches TIMEOUT-1 with no ACK -> ERR, FETCH_ERR<=1 (ACK on that same cycle wins: normal capture).
//  OUT: INSTR_VALID=1; HOLD=1 -> stay, outputs frozen; HOLD=0 -> INSTR_VALID<=0, -> FETCH (consumed).
//  Throughput: max one instruction per 2 cycles (FETCH+OUT); latency ACK->VALID = 1 cycle.
//  ERR: IMEM_REQ=0, INSTR_VALID=0; exited only by REDIRECT (-> FETCH, FETCH_ERR<=0) or RST.
//  REDIRECT (any state except during RST): highest priority after RST; PC<=REDIRECT_PC, INSTR_VALID<=0, wait cnt<=0, FETCH_ERR<=0, -> FETCH.
//    Simultaneous ACK+REDIRECT in FETCH: IMEM_RDATA discarded, INSTR unchanged, PC not incremented.
//    REDIRECT overrides HOLD in OUT: held instruction dropped.
//  INSTR/IMM20/INSTR_PC retain last values when INSTR_VALID=0 (not cleared except by RST).
//  RST mid-fetch: request drops next cycle; any late ACK in IDLE ignored.
//  IMEM_ACK outside FETCH ignored.
// CONFIGURATION
//  Macro IF_FETCH_CNT_EN:
//   defined: extra port FETCH_CNT out 32 = count of consumed instructions (OUT && !HOLD && !REDIRECT);
//     reset 0 by RST only (REDIRECT does not clear); wraps 32'hFFFF_FFFF -> 0.
//   undefined: port and counter absent; all other behaviour identical.
// TESTING
//  Reset, RESET_PC=0, memory ACKs in 1 cycle with RDATA=32'h12345_0B7 -> IMM20=20'h12345, INSTR_PC=0, VALID after 1 cycle; next IMEM_ADDR=4.
//  HOLD=1 for 3 cycles in OUT -> INSTR/VALID stable, IMEM_REQ=0; HOLD drop -> VALID low next cycle, request at PC+4.
//  REDIRECT=1, REDIRECT_PC=32'h100 same cycle as ACK -> data dropped, VALID=0, next IMEM_ADDR=32'h100.
//  No ACK for TIMEOUT=8 cycles -> FETCH_ERR=1, IMEM_REQ=0; REDIRECT to 32'h40 -> FETCH_ERR=0, request at 32'h40.
//  PC=32'hFFFF_FFFC fetch accepted -> next IMEM_ADDR=32'h0000_0000 (wrap).
//  With IF_FETCH_CNT_EN: 5 consumed fetches + 1 redirect-dropped -> FETCH_CNT=5; RST -> 0.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// Fetch stage: owns the PC, handshakes with IMEM under a watchdog, and registers INSTR/IMM20 for decode.
// Optional macro IF_FETCH_CNT_EN adds o_fetch_cnt, a wrapping count of consumed instructions.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4,
    parameter int unsigned TIMEOUT  = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_hold,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic [19:0] o_imm20,
    output logic        o_instr_valid,
    output logic        o_fetch_err
`ifdef IF_FETCH_CNT_EN
    ,
    output logic [31:0] o_fetch_cnt
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic [19:0] r_imm20;
    logic        r_valid;
    logic        r_err;
    logic [7:0]  r_wait_cnt;

    assign o_imem_req    = (r_state == S_FETCH);
    assign o_imem_addr   = r_pc;
    assign o_instr       = r_instr;
    assign o_instr_pc    = r_instr_pc;
    assign o_imm20       = r_imm20;
    assign o_instr_valid = r_valid;
    assign o_fetch_err   = r_err;

    // Redirect outranks everything but reset, so an ACK or HOLD arriving with it is dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_instr    <= 32'd0;
            r_instr_pc <= 32'd0;
            r_imm20    <= 20'd0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_wait_cnt <= 8'd0;
        end else if (i_redirect) begin
            r_pc       <= i_redirect_pc;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_wait_cnt <= 8'd0;
            r_state    <= S_FETCH;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (i_imem_ack) begin
                        r_instr    <= i_imem_rdata;
                        r_imm20    <= i_imem_rdata[31:12];
                        r_instr_pc <= r_pc;
                        r_pc       <= r_pc + PC_STEP;
                        r_valid    <= 1'b1;
                        r_wait_cnt <= 8'd0;
                        r_state    <= S_OUT;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_err      <= 1'b1;
                        r_wait_cnt <= 8'd0;
                        r_state    <= S_ERR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                S_OUT: begin
                    if (!i_hold) begin
                        r_valid <= 1'b0;
                        r_state <= S_FETCH;
                    end
                end
                S_ERR: begin
                    r_state <= S_ERR;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef IF_FETCH_CNT_EN
    logic        w_consume;
    logic [31:0] r_fetch_cnt;

    assign w_consume   = (r_state == S_OUT) && !i_hold && !i_redirect;
    assign o_fetch_cnt = r_fetch_cnt;

    // Only reset clears the count; redirects leave it alone.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_cnt <= 32'd0;
        end else if (w_consume) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed vectors, a transaction-level reference model checked every cycle,
// plus literal expectations at key points.
module tb_instr_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TIMEOUT  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ack = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic        hold = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirectPc = 32'd0;

    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] instrPc;
    logic [19:0] imm20;
    logic        valid;
    logic        fetchErr;
`ifdef IF_FETCH_CNT_EN
    logic [31:0] fetchCnt;
`endif

    int nCompared   = 0;
    int nMismatched = 0;

    instr_fetch_stage #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (32'd4),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_imem_req    (req),
        .o_imem_addr   (addr),
        .i_imem_ack    (ack),
        .i_imem_rdata  (rdata),
        .i_hold        (hold),
        .i_redirect    (redirect),
        .i_redirect_pc (redirectPc),
        .o_instr       (instr),
        .o_instr_pc    (instrPc),
        .o_imm20       (imm20),
        .o_instr_valid (valid),
        .o_fetch_err   (fetchErr)
`ifdef IF_FETCH_CNT_EN
        ,
        .o_fetch_cnt   (fetchCnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: tracks what the stage is doing (waiting on memory, presenting, stuck) and
    // how many unanswered request cycles have elapsed.
    typedef enum {M_IDLE, M_WAITMEM, M_PRESENT, M_STUCK} mode_t;
    mode_t       mMode = M_IDLE;
    logic [31:0] mPc = 32'd0;
    logic [31:0] mInstr = 32'd0;
    logic [31:0] mInstrPc = 32'd0;
    logic        mValid = 1'b0;
    logic        mErr = 1'b0;
    int          mMissed = 0;
    logic [31:0] mConsumed = 32'd0;
    logic        modelLive = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mMode = M_IDLE; mPc = RESET_PC; mInstr = 0; mInstrPc = 0;
            mValid = 0; mErr = 0; mMissed = 0; mConsumed = 0; modelLive = 1;
        end else if (redirect) begin
            mPc = redirectPc; mValid = 0; mErr = 0; mMissed = 0; mMode = M_WAITMEM;
        end else begin
            case (mMode)
                M_IDLE: mMode = M_WAITMEM;
                M_WAITMEM: begin
                    if (ack) begin
                        mInstr = rdata; mInstrPc = mPc; mPc = mPc + 32'd4;
                        mValid = 1; mMissed = 0; mMode = M_PRESENT;
                    end else begin
                        mMissed = mMissed + 1;
                        if (mMissed == TIMEOUT) begin
                            mErr = 1; mMissed = 0; mMode = M_STUCK;
                        end
                    end
                end
                M_PRESENT: begin
                    if (!hold) begin
                        mValid = 0; mConsumed = mConsumed + 32'd1; mMode = M_WAITMEM;
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared = nCompared + 1;
        if (act !== exp) begin
            nMismatched = nMismatched + 1;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compareModel();
        if (modelLive) begin
            checkOutput("m_req",   {31'd0, req},      {31'd0, mMode == M_WAITMEM});
            checkOutput("m_addr",  addr,              mPc);
            checkOutput("m_valid", {31'd0, valid},    {31'd0, mValid});
            checkOutput("m_err",   {31'd0, fetchErr}, {31'd0, mErr});
            checkOutput("m_instr", instr,             mInstr);
            checkOutput("m_ipc",   instrPc,           mInstrPc);
            checkOutput("m_imm20", {12'd0, imm20},    {12'd0, mInstr[31:12]});
`ifdef IF_FETCH_CNT_EN
            checkOutput("m_cnt",   fetchCnt,          mConsumed);
`endif
        end
    endtask

    // Drive one cycle of inputs, let the edge pass, then compare on the falling edge.
    task automatic applyStimulus(input logic r, input logic a, input logic [31:0] d,
                                 input logic h, input logic rd, input logic [31:0] rpc);
        rst = r; ack = a; rdata = d; hold = h; redirect = rd; redirectPc = rpc;
        @(posedge clk);
        @(negedge clk);
        compareModel();
    endtask

    initial begin
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("rst_req",   {31'd0, req},      0);
        checkOutput("rst_valid", {31'd0, valid},    0);
        checkOutput("rst_err",   {31'd0, fetchErr}, 0);
        checkOutput("rst_instr", instr,             0);
        checkOutput("rst_addr",  addr,              0);

        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("first_req",  {31'd0, req}, 1);
        checkOutput("first_addr", addr,         0);

        applyStimulus(0, 1, 32'h1234_50B7, 0, 0, 0);
        checkOutput("cap_valid", {31'd0, valid},   1);
        checkOutput("cap_imm20", {12'd0, imm20},   32'h0001_2345);
        checkOutput("cap_ipc",   instrPc,          0);
        checkOutput("cap_addr",  addr,             32'd4);
        checkOutput("cap_req",   {31'd0, req},     0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 1, 0, 0);
            checkOutput("hold_valid", {31'd0, valid}, 1);
            checkOutput("hold_req",   {31'd0, req},   0);
            checkOutput("hold_instr", instr,          32'h1234_50B7);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("drop_valid", {31'd0, valid}, 0);
        checkOutput("drop_req",   {31'd0, req},   1);
        checkOutput("drop_addr",  addr,           32'd4);

        applyStimulus(0, 1, 32'hAABB_CCDD, 0, 0, 0);
        checkOutput("second_ipc", instrPc, 32'd4);
        applyStimulus(0, 0, 0, 0, 0, 0);

        applyStimulus(0, 1, 32'h0BAD_F00D, 0, 1, 32'h100);
        checkOutput("redir_valid", {31'd0, valid}, 0);
        checkOutput("redir_addr",  addr,           32'h100);
        checkOutput("redir_instr", instr,          32'hAABB_CCDD);

        for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("wd_early_err", {31'd0, fetchErr}, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("wd_err", {31'd0, fetchErr}, 1);
        checkOutput("wd_req", {31'd0, req},      0);
        applyStimulus(0, 1, 32'h5555_5555, 0, 0, 0);
        checkOutput("err_ack_valid", {31'd0, valid},    0);
        checkOutput("err_ack_err",   {31'd0, fetchErr}, 1);

        applyStimulus(0, 0, 0, 0, 1, 32'h40);
        checkOutput("recover_err",  {31'd0, fetchErr}, 0);
        checkOutput("recover_req",  {31'd0, req},      1);
        checkOutput("recover_addr", addr,              32'h40);

        for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'hCAFE_1337, 0, 0, 0);
        checkOutput("lastack_valid", {31'd0, valid},    1);
        checkOutput("lastack_err",   {31'd0, fetchErr}, 0);
        checkOutput("lastack_ipc",   instrPc,           32'h40);
        applyStimulus(0, 0, 0, 0, 0, 0);

        applyStimulus(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        applyStimulus(0, 1, 32'h0000_1111, 0, 0, 0);
        checkOutput("wrap_addr", addr,    32'h0);
        checkOutput("wrap_ipc",  instrPc, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 0, 0, 0);

        applyStimulus(0, 1, 32'h2222_3333, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 32'h200);
        checkOutput("holdredir_valid", {31'd0, valid}, 0);
        checkOutput("holdredir_addr",  addr,           32'h200);
        applyStimulus(0, 1, 32'h4444_5555, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
`ifdef IF_FETCH_CNT_EN
        checkOutput("cnt_five", fetchCnt, 32'd5);
`endif

        applyStimulus(1, 1, 32'h7777_8888, 0, 0, 0);
        checkOutput("midrst_req",   {31'd0, req},   0);
        checkOutput("midrst_instr", instr,          0);
`ifdef IF_FETCH_CNT_EN
        checkOutput("cnt_rst", fetchCnt, 32'd0);
`endif
        applyStimulus(0, 1, 32'h7777_8888, 0, 0, 0);
        checkOutput("lateack_valid", {31'd0, valid}, 0);
        checkOutput("lateack_req",   {31'd0, req},   1);
        applyStimulus(0, 1, 32'h9999_AAAA, 0, 0, 0);
        checkOutput("post_instr", instr,   32'h9999_AAAA);
        checkOutput("post_ipc",   instrPc, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
